// File: rtl/pipelined_mem_requester.sv
// Initiator-side front end for the fixed-latency pipelined data memory.
// Issues at most one load/store per cycle, tracks loads through the memory
// latency and buffers the returned words in a response FIFO. Credits cover
// in-flight and buffered loads, so the FIFO never overflows.

module pipelined_mem_requester_chk #(
  parameter int CNT_W      = 4,
  parameter int RESP_DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push_s,
  input logic [CNT_W-1:0] count_q
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

  // A returning load must always find room in the response FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_s && (count_q == DEPTH_C)));

  // The stored count never exceeds the FIFO capacity.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);
endmodule

module pipelined_mem_requester #(
  parameter int LATENCY    = 5,
  parameter int RESP_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [9:0]       req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic [9:0]       mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic             init_q, init_d;
  logic [9:0]       mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_din_q, mem_din_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LATENCY];
  logic [TAG_W-1:0] tag_d [LATENCY];
  logic [31:0]      fdata_q [RESP_DEPTH];
  logic [31:0]      fdata_d [RESP_DEPTH];
  logic [TAG_W-1:0] ftag_q [RESP_DEPTH];
  logic [TAG_W-1:0] ftag_d [RESP_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] occ_s;
  logic             accept_s, push_s, pop_s;

  // Occupancy: loads still in the memory pipeline plus buffered responses.
  always_comb begin
    occ_s = count_q;
    for (int i = 0; i < LATENCY; i++) begin
      if (vld_q[i]) begin
        occ_s = occ_s + CNT_ONE;
      end else begin
        occ_s = occ_s;
      end
    end
  end

  // init_q holds ready low for the first cycle after reset release.
  assign req_ready  = init_q && (occ_s < DEPTH_C);
  assign busy       = (occ_s != {CNT_W{1'b0}});
  assign accept_s   = req_valid && req_ready;
  assign push_s     = vld_q[LATENCY-1];
  assign pop_s      = resp_ready && (count_q != {CNT_W{1'b0}});
  assign resp_valid = (count_q != {CNT_W{1'b0}});
  assign resp_rdata = fdata_q[rd_ptr_q];
  assign resp_tag   = ftag_q[rd_ptr_q];
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;

  // Next state: memory drive, read tracker shift and response FIFO update.
  always_comb begin
    init_d     = 1'b1;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    if (accept_s) begin
      mem_addr_d = req_addr;
      mem_din_d  = req_wdata;
      mem_we_d   = req_we;
    end else begin
      mem_we_d   = 1'b0;
    end

    vld_d    = {vld_q[LATENCY-2:0], accept_s && !req_we};
    tag_d[0] = req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    fdata_d  = fdata_q;
    ftag_d   = ftag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      fdata_d[wr_ptr_q] = mem_dout;
      ftag_d[wr_ptr_q]  = tag_q[LATENCY-1];
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d          = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops tracked loads so late memory data is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      mem_addr_q <= 10'd0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= 32'd0;
      vld_q      <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= {TAG_W{1'b0}};
      end
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fdata_q[i] <= 32'd0;
        ftag_q[i]  <= {TAG_W{1'b0}};
      end
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
    end else begin
      init_q     <= init_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      fdata_q    <= fdata_d;
      ftag_q     <= ftag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  pipelined_mem_requester_chk #(
    .CNT_W      (CNT_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_s  (push_s),
    .count_q (count_q)
  );
endmodule

// File: tb/tb_pipelined_mem_requester.sv
// Bench for pipelined_mem_requester: a 4-stage memory model plus a
// transaction-level reference (shadow memory and an expected-response queue
// stamped with the cycle each response becomes visible).

module tb_pipelined_mem_requester;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_tag;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_din, mem_dout;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_tag;
  logic        busy;

  pipelined_mem_requester #(.LATENCY(5), .RESP_DEPTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pipelined memory without reset: array access, then three more stages to dout.
  logic [31:0] mem_arr [1024];
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_din;
    p0       <= mem_arr[mem_addr];
    p1       <= p0;
    p2       <= p1;
    mem_dout <= p2;
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          vis;
  } exp_t;

  exp_t        q[$];
  logic [31:0] shadow [1024];
  int          cyc = 0, checks = 0, errors = 0;
  int          dut_pops = 0, dut_accs = 0;
  logic        rst_done = 1'b0;
  logic [9:0]  e_addr = 10'd0;
  logic        e_we = 1'b0;
  logic [31:0] e_din = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic e_ready, e_valid;
    e_ready = rst_done && (q.size() < 8);
    e_valid = (q.size() > 0) && (q[0].vis <= cyc);
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, q.size() != 0);
    chk("resp_valid", resp_valid, e_valid);
    if (e_valid) begin
      chk("resp_rdata", resp_rdata, q[0].data);
      chk("resp_tag", resp_tag, q[0].tag);
    end
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_din", mem_din, e_din);
  endtask

  // One clock: decide handshakes from the model, advance it, check after the edge.
  task automatic tick(output logic acc);
    logic e_ready, e_valid, pop;
    e_ready = rst_done && (q.size() < 8);
    e_valid = (q.size() > 0) && (q[0].vis <= cyc);
    acc = rst_n && req_valid && e_ready;
    pop = rst_n && resp_ready && e_valid;
    if (resp_valid === 1'b1 && resp_ready) dut_pops++;
    if (req_valid && req_ready === 1'b1) dut_accs++;
    if (pop) void'(q.pop_front());
    e_we = 1'b0;
    if (acc) begin
      e_addr = req_addr;
      e_din  = req_wdata;
      e_we   = req_we;
      if (req_we) shadow[req_addr] = req_wdata;
      else q.push_back('{data: shadow[req_addr], tag: req_tag, vis: cyc + 6});
    end
    @(posedge clk);
    rst_done = rst_n;
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic a;
    req_valid = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic send(input logic we, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] t);
    logic acc;
    int   k;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_tag = t;
    k = 0;
    tick(acc);
    while (!acc && k < 40) begin k++; tick(acc); end
    chk("send_accepted", acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    logic a;
    rst_n = 1'b0;
    #1;
    q.delete();
    rst_done = 1'b0; e_addr = 10'd0; e_we = 1'b0; e_din = 32'd0;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_tag", resp_tag, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    repeat (n) tick(a);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", req_ready, 1'b0);
  endtask

  task automatic drain(input int bound);
    int k;
    logic a;
    req_valid = 1'b0; resp_ready = 1'b1; k = 0;
    while (q.size() > 0 && k < bound) begin tick(a); k++; end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic acc;
    int   load_c, first_c, nvalid, base, stalls, accepted;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'd0;
    req_wdata = 32'd0; req_tag = 4'd0; resp_ready = 1'b1;
    @(negedge clk);
    do_reset(3);

    // Store then load to the same address.
    send(1'b1, 10'h005, 32'hDEADBEEF, 4'd0);
    send(1'b0, 10'h005, 32'h0, 4'd2);
    load_c = cyc - 1; first_c = -1; nvalid = 0;
    repeat (12) begin
      tick(acc);
      if (resp_valid === 1'b1) begin
        nvalid++;
        if (first_c < 0) first_c = cyc;
      end
    end
    chk("t2_resp_cycle", first_c - load_c, 6);
    chk("t2_resp_count", nvalid, 1);

    // Streaming: pre-store, then 16 back-to-back loads.
    for (int i = 0; i < 16; i++) send(1'b1, 10'(i), 32'(i) * 32'h11, 4'd0);
    base = dut_pops; stalls = 0;
    for (int i = 0; i < 16; i++) begin
      if (req_ready !== 1'b1) stalls++;
      send(1'b0, 10'(i), 32'h0, 4'(i));
    end
    chk("t3_no_stall", stalls, 0);
    drain(40);
    chk("t3_resp_count", dut_pops - base, 16);

    // Reset during load traffic.
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 10'($urandom_range(0, 15)); req_tag = 4'(i);
      tick(acc);
    end
    do_reset(3);
    req_valid = 1'b0;
    idle(10);

    // Backpressure: 10 loads offered, only 8 credits.
    resp_ready = 1'b0; accepted = 0; base = dut_accs;
    for (int k = 0; k < 20; k++) begin
      req_valid = (accepted < 10); req_we = 1'b0;
      req_addr = 10'(accepted); req_tag = 4'(accepted);
      tick(acc);
      if (acc) accepted++;
    end
    chk("t4_accepted", dut_accs - base, 8);
    base = dut_pops; resp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      req_valid = (accepted < 10);
      req_addr = 10'(accepted); req_tag = 4'(accepted);
      tick(acc);
      if (acc) accepted++;
    end
    req_valid = 1'b0;
    chk("t4_total_resp", dut_pops - base, 10);

    // Full FIFO blocks a store until the first pop.
    resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 10'(i), 32'h0, 4'(i));
    idle(8);
    base = dut_accs;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h003; req_wdata = 32'hA5A50003;
    repeat (4) tick(acc);
    chk("t5_store_blocked", dut_accs - base, 0);
    resp_ready = 1'b1;
    tick(acc);
    resp_ready = 1'b0;
    tick(acc);
    chk("t5_store_after_pop", dut_accs - base, 1);
    chk("t5_mem_we", mem_we, 1'b1);
    req_valid = 1'b0;
    drain(40);

    // Reset with loads in flight.
    resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 10'(i + 4); req_tag = 4'(i);
      tick(acc);
    end
    idle(2);
    do_reset(2);
    base = dut_pops;
    idle(12);
    chk("t6_no_resp", dut_pops - base, 0);
    send(1'b0, 10'h007, 32'h0, 4'd9);
    drain(20);
    chk("t6_one_resp", dut_pops - base, 1);

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = ($urandom_range(0, 2) == 0);
      req_addr   = 10'($urandom_range(0, 15));
      req_wdata  = $urandom;
      req_tag    = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
